// File: rtl/pp_burst_ctrl.sv
// Burst push/pop engine between the operand stack and data memory.
// Define PP_MEM_TIMEOUT_EN to abort RD/WR after TIMEOUT cycles without mem_ready.
module pp_burst_ctrl #(
    parameter int ADDR_LEN = 8,
    parameter int DATA_LEN = 8,
    parameter int CNT_LEN  = 4,
    parameter int TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                en,
    input  logic [1:0]          opc,
    input  logic [ADDR_LEN-1:0] base_addr,
    input  logic [CNT_LEN-1:0]  count,
    input  logic [DATA_LEN-1:0] const_data,
    input  logic                stk_full,
    input  logic                stk_empty,
    input  logic [DATA_LEN-1:0] stk_data_out,
    output logic                stk_push,
    output logic                stk_pop,
    output logic [DATA_LEN-1:0] stk_data_in,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic                mem_r_en,
    output logic                mem_w_en,
    output logic [DATA_LEN-1:0] mem_data_in,
    input  logic [DATA_LEN-1:0] mem_data_out,
    input  logic                mem_ready,
    output logic                busy,
    output logic                done,
    output logic                err
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_PUSH, S_POP, S_POP_W, S_WR, S_DONE
    } state_t;

    localparam logic [1:0] OPC_PUSHC = 2'b00;
    localparam logic [1:0] OPC_PUSHM = 2'b01;
    localparam logic [1:0] OPC_POPM  = 2'b10;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("pp_burst_ctrl: TIMEOUT must be at least 1");
    end

    state_t                state, state_nx;
    logic [1:0]            opc_reg, opc_nx;
    logic [ADDR_LEN-1:0]   addr_reg, addr_nx;
    logic [CNT_LEN-1:0]    rem, rem_nx;
    logic [DATA_LEN-1:0]   data_reg, data_nx;
    logic                  err_flag, err_nx;
    logic                  mem_timeout;

`ifdef PP_MEM_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    logic [WAIT_W-1:0] wait_cnt;

    // Restarts on every state change, so each RD/WR visit gets a fresh budget.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt <= '0;
        end else if (state_nx != state) begin
            wait_cnt <= '0;
        end else if (state == S_RD || state == S_WR) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    assign mem_timeout = (wait_cnt == WAIT_W'(TIMEOUT - 1));
`else
    assign mem_timeout = 1'b0;
`endif

    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            opc_reg  <= '0;
            addr_reg <= '0;
            rem      <= '0;
            data_reg <= '0;
            err_flag <= 1'b0;
        end else begin
            state    <= state_nx;
            opc_reg  <= opc_nx;
            addr_reg <= addr_nx;
            rem      <= rem_nx;
            data_reg <= data_nx;
            err_flag <= err_nx;
        end
    end

    // NOTE: every output and next-value gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx    = state;
        opc_nx      = opc_reg;
        addr_nx     = addr_reg;
        rem_nx      = rem;
        data_nx     = data_reg;
        err_nx      = err_flag;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        stk_data_in = '0;
        mem_addr    = '0;
        mem_r_en    = 1'b0;
        mem_w_en    = 1'b0;
        mem_data_in = '0;
        done        = 1'b0;
        err         = 1'b0;
        busy        = (state != S_IDLE);

        unique case (state)
            S_IDLE: begin
                if (en) begin
                    opc_nx  = opc;
                    addr_nx = base_addr;
                    rem_nx  = count;
                    data_nx = const_data;
                    err_nx  = 1'b0;
                    if (count == '0) begin
                        state_nx = S_DONE;
                    end else begin
                        unique case (opc)
                            OPC_PUSHC: state_nx = S_PUSH;
                            OPC_PUSHM: state_nx = S_RD;
                            OPC_POPM:  state_nx = S_POP;
                            default: begin
                                err_nx   = 1'b1;
                                state_nx = S_DONE;
                            end
                        endcase
                    end
                end
            end

            S_RD: begin
                mem_r_en = 1'b1;
                mem_addr = addr_reg;
                if (mem_ready) begin
                    data_nx  = mem_data_out;
                    state_nx = S_PUSH;
                end else if (mem_timeout) begin
                    err_nx   = 1'b1;
                    state_nx = S_DONE;
                end
            end

            S_PUSH: begin
                if (stk_full) begin
                    err_nx   = 1'b1;
                    state_nx = S_DONE;
                end else begin
                    stk_push    = 1'b1;
                    stk_data_in = data_reg;
                    rem_nx      = rem - CNT_LEN'(1);
                    addr_nx     = addr_reg + ADDR_LEN'(1);
                    if (rem == CNT_LEN'(1)) begin
                        state_nx = S_DONE;
                    end else if (opc_reg == OPC_PUSHM) begin
                        state_nx = S_RD;
                    end else begin
                        state_nx = S_PUSH;
                    end
                end
            end

            S_POP: begin
                if (stk_empty) begin
                    err_nx   = 1'b1;
                    state_nx = S_DONE;
                end else begin
                    stk_pop  = 1'b1;
                    state_nx = S_POP_W;
                end
            end

            // Stack top is only valid the cycle after the pop strobe.
            S_POP_W: begin
                data_nx  = stk_data_out;
                state_nx = S_WR;
            end

            S_WR: begin
                mem_w_en    = 1'b1;
                mem_addr    = addr_reg;
                mem_data_in = data_reg;
                if (mem_ready) begin
                    rem_nx   = rem - CNT_LEN'(1);
                    addr_nx  = addr_reg + ADDR_LEN'(1);
                    state_nx = (rem == CNT_LEN'(1)) ? S_DONE : S_POP;
                end else if (mem_timeout) begin
                    err_nx   = 1'b1;
                    state_nx = S_DONE;
                end
            end

            S_DONE: begin
                done     = 1'b1;
                err      = err_flag;
                state_nx = S_IDLE;
            end

            default: state_nx = S_IDLE;
        endcase
    end

    a_mem_excl: assert property (@(posedge clk) disable iff (!rstn) !(mem_r_en && mem_w_en));
    a_stk_excl: assert property (@(posedge clk) disable iff (!rstn) !(stk_push && stk_pop));
    a_err_done: assert property (@(posedge clk) disable iff (!rstn) err |-> done);

endmodule

// File: tb/tb_pp_burst_ctrl.sv
// Randomized bench for pp_burst_ctrl: behavioural stack/memory responders plus a
// transaction-level model predicting pushes, reads, writes, pops, err and latency.
module tb_pp_burst_ctrl;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int CW = 4;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          en = 1'b0;
    logic [1:0]    opc = '0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] count = '0;
    logic [DW-1:0] const_data = '0;
    logic          stk_full = 1'b0;
    logic          stk_empty = 1'b1;
    logic [DW-1:0] stk_data_out = '0;
    logic          stk_push, stk_pop;
    logic [DW-1:0] stk_data_in;
    logic [AW-1:0] mem_addr;
    logic          mem_r_en, mem_w_en;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out = '0;
    logic          mem_ready = 1'b0;
    logic          busy, done, err;

    pp_burst_ctrl #(.ADDR_LEN(AW), .DATA_LEN(DW), .CNT_LEN(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn), .en(en), .opc(opc), .base_addr(base_addr),
        .count(count), .const_data(const_data), .stk_full(stk_full),
        .stk_empty(stk_empty), .stk_data_out(stk_data_out), .stk_push(stk_push),
        .stk_pop(stk_pop), .stk_data_in(stk_data_in), .mem_addr(mem_addr),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .mem_ready(mem_ready), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Environment state: stack top is the back of the queue.
    logic [DW-1:0]      stk_q[$];
    int                 stk_cap = 0;
    logic [DW-1:0]      mem_arr[256];
    bit                 hold_ready = 1'b0;
    int                 wait_left = -1;
    int                 total_waits = 0;
    bit                 pop_pending = 1'b0;
    logic [DW-1:0]      pop_val = '0;
    logic [DW-1:0]      obs_push[$];
    logic [AW-1:0]      obs_rd[$];
    logic [AW+DW-1:0]   obs_wr[$];
    int                 obs_pops = 0;

    // Stack and memory responders: drive inputs at negedge, record committed traffic just after.
    initial begin
        forever begin
            @(negedge clk);
            stk_full  = (stk_q.size() >= stk_cap);
            stk_empty = (stk_q.size() == 0);
            if (pop_pending) begin
                stk_data_out = pop_val;
                pop_pending  = 1'b0;
            end
            if ((mem_r_en || mem_w_en) && rstn) begin
                if (hold_ready) begin
                    mem_ready = 1'b0;
                    total_waits++;
                end else begin
                    if (wait_left < 0) wait_left = int'($urandom_range(0, 3));
                    if (wait_left == 0) begin
                        mem_ready    = 1'b1;
                        mem_data_out = mem_arr[mem_addr];
                    end else begin
                        mem_ready = 1'b0;
                        wait_left--;
                        total_waits++;
                    end
                end
            end else begin
                mem_ready = 1'b0;
                wait_left = -1;
            end
            #1;
            check("mem_excl", 32'(mem_r_en & mem_w_en), 32'd0);
            check("stk_excl", 32'(stk_push & stk_pop), 32'd0);
            check("err_without_done", 32'(err & ~done), 32'd0);
            if (stk_push) begin
                obs_push.push_back(stk_data_in);
                stk_q.push_back(stk_data_in);
            end
            if (stk_pop) begin
                pop_val     = (stk_q.size() > 0) ? stk_q.pop_back() : '0;
                pop_pending = 1'b1;
                obs_pops++;
            end
            if (mem_ready && mem_r_en) obs_rd.push_back(mem_addr);
            if (mem_ready && mem_w_en) begin
                obs_wr.push_back({mem_addr, mem_data_in});
                mem_arr[mem_addr] = mem_data_in;
            end
            if (mem_ready) wait_left = -1;
        end
    end

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic set_stack(input int size, input int cap);
        stk_q.delete();
        for (int i = 0; i < size; i++) stk_q.push_back(DW'($urandom));
        stk_cap = cap;
    endtask

    // Predicts the burst outcome from the command and the environment, then runs it.
    task automatic run_cmd(input logic [1:0] c_opc, input logic [AW-1:0] c_base,
                           input logic [CW-1:0] c_cnt, input logic [DW-1:0] c_const,
                           input string tag);
        logic [DW-1:0]    exp_push[$];
        logic [AW-1:0]    exp_rd[$];
        logic [AW+DW-1:0] exp_wr[$];
        logic [AW-1:0]    a;
        int  n, size, room, k, n_rd, exp_lat, exp_pops, lat;
        bit  exp_err, got_done;

        n = int'(c_cnt);
        size = stk_q.size();
        room = stk_cap - size;
        exp_err = 1'b0;
        exp_lat = 1;
        exp_pops = 0;
        if (n == 0) begin
            exp_err = 1'b0;
        end else if (c_opc == 2'b11) begin
            exp_err = 1'b1;
        end else if (c_opc == 2'b10) begin
            k = imin(n, size);
            for (int i = 0; i < k; i++) begin
                a = c_base + AW'(i);
                exp_wr.push_back({a, stk_q[size - 1 - i]});
            end
            exp_pops = k;
            exp_err  = (k < n);
            exp_lat  = exp_err ? 3 * k + 2 : 3 * n + 1;
        end else begin
            k = imin(n, room);
            exp_err = (k < n);
            for (int i = 0; i < k; i++) begin
                a = c_base + AW'(i);
                exp_push.push_back((c_opc == 2'b00) ? c_const : mem_arr[a]);
            end
            if (c_opc == 2'b01) begin
                n_rd = exp_err ? k + 1 : n;
                for (int i = 0; i < n_rd; i++) exp_rd.push_back(c_base + AW'(i));
                exp_lat = exp_err ? 2 * k + 3 : 2 * n + 1;
            end else begin
                exp_lat = exp_err ? k + 2 : n + 1;
            end
        end

        obs_push.delete();
        obs_rd.delete();
        obs_wr.delete();
        obs_pops = 0;
        total_waits = 0;

        @(negedge clk);
        en = 1'b1; opc = c_opc; base_addr = c_base; count = c_cnt; const_data = c_const;
        @(posedge clk);
        #1;
        en = 1'b0; opc = 2'($urandom); base_addr = AW'($urandom); count = CW'($urandom);
        const_data = DW'($urandom);

        lat = 0;
        got_done = 1'b0;
        while (!got_done && lat < 400) begin
            @(negedge clk);
            #2;
            lat++;
            if (lat == 1) check({tag, "_busy"}, 32'(busy), 32'd1);
            if (done) got_done = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(got_done), 32'd1);
        if (!got_done) return;
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat + total_waits));
        @(negedge clk);
        #2;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);

        check({tag, "_n_push"}, 32'(obs_push.size()), 32'(exp_push.size()));
        for (int i = 0; i < imin(obs_push.size(), exp_push.size()); i++)
            check({tag, "_push_data"}, 32'(obs_push[i]), 32'(exp_push[i]));
        check({tag, "_n_rd"}, 32'(obs_rd.size()), 32'(exp_rd.size()));
        for (int i = 0; i < imin(obs_rd.size(), exp_rd.size()); i++)
            check({tag, "_rd_addr"}, 32'(obs_rd[i]), 32'(exp_rd[i]));
        check({tag, "_n_wr"}, 32'(obs_wr.size()), 32'(exp_wr.size()));
        for (int i = 0; i < imin(obs_wr.size(), exp_wr.size()); i++)
            check({tag, "_wr_addr_data"}, 32'(obs_wr[i]), 32'(exp_wr[i]));
        check({tag, "_n_pop"}, 32'(obs_pops), 32'(exp_pops));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [1:0] r_opc;
        bit seen_wr;

        for (int i = 0; i < 256; i++) mem_arr[i] = DW'($urandom);
        set_stack(0, 8);

        repeat (3) @(negedge clk);
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_strobes", 32'({stk_push, stk_pop, mem_r_en, mem_w_en, err}), 32'd0);
        check("rst_data", 32'({stk_data_in, mem_addr, mem_data_in}), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        set_stack(0, 16);
        run_cmd(2'b00, 8'h00, 4'd3, 8'h5A, "pushc_5a");

        set_stack(0, 16);
        mem_arr[8'h10] = 8'h11;
        mem_arr[8'h11] = 8'h22;
        run_cmd(2'b01, 8'h10, 4'd2, 8'h00, "pushm_10");

        stk_q.delete();
        stk_q.push_back(8'hC3);
        stk_q.push_back(8'hB2);
        stk_q.push_back(8'hA1);
        stk_cap = 8;
        run_cmd(2'b10, 8'hFE, 4'd3, 8'h00, "popm_wrap");

        set_stack(2, 8);
        run_cmd(2'b10, 8'h40, 4'd4, 8'h00, "popm_empty");

        set_stack(1, 8);
        run_cmd(2'b11, 8'h20, 4'd5, 8'h00, "opc_rsvd");
        run_cmd(2'b00, 8'h20, 4'd0, 8'h33, "count_zero");

        set_stack(3, 5);
        run_cmd(2'b00, 8'h00, 4'd4, 8'h77, "pushc_full");
        set_stack(2, 3);
        run_cmd(2'b01, 8'hFF, 4'd3, 8'h00, "pushm_full");
        set_stack(0, 15);
        run_cmd(2'b00, 8'h00, 4'd15, 8'hE1, "pushc_max");

        for (int t = 0; t < 60; t++) begin
            r = int'($urandom_range(0, 9));
            r_opc = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            r = int'($urandom_range(0, 6));
            set_stack(r, r + int'($urandom_range(0, 16)));
            run_cmd(r_opc, AW'($urandom), CW'($urandom_range(0, 15)), DW'($urandom), "rand");
        end

        // Asynchronous reset while a POPM write is stalled.
        set_stack(3, 8);
        hold_ready = 1'b1;
        @(negedge clk);
        en = 1'b1; opc = 2'b10; base_addr = 8'h80; count = 4'd2;
        @(posedge clk);
        #1;
        en = 1'b0;
        seen_wr = 1'b0;
        for (int c = 0; c < 20 && !seen_wr; c++) begin
            @(negedge clk);
            #2;
            if (mem_w_en) seen_wr = 1'b1;
        end
        check("rst_mid_reached_wr", 32'(seen_wr), 32'd1);
        #1;
        rstn = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_strobes", 32'({stk_push, stk_pop, mem_r_en, mem_w_en, done, err}), 32'd0);
        check("rst_mid_data", 32'({stk_data_in, mem_addr, mem_data_in}), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #2;
            check("rst_mid_no_done", 32'(done), 32'd0);
        end
        hold_ready = 1'b0;
        @(negedge clk);
        rstn = 1'b1;

        set_stack(1, 6);
        run_cmd(2'b00, 8'h00, 4'd2, 8'h3C, "after_reset");

`ifdef PP_MEM_TIMEOUT_EN
        begin
            int lat;
            bit got;
            set_stack(0, 8);
            hold_ready = 1'b1;
            obs_push.delete();
            @(negedge clk);
            en = 1'b1; opc = 2'b01; base_addr = 8'h30; count = 4'd2;
            @(posedge clk);
            #1;
            en = 1'b0;
            lat = 0;
            got = 1'b0;
            while (!got && lat < 100) begin
                @(negedge clk);
                #2;
                lat++;
                if (done) got = 1'b1;
            end
            check("timeout_done_seen", 32'(got), 32'd1);
            check("timeout_latency", 32'(lat), 32'(TO + 1));
            check("timeout_err", 32'(err), 32'd1);
            check("timeout_no_push", 32'(obs_push.size()), 32'd0);
            hold_ready = 1'b0;
            @(negedge clk);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
